regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS datapath.
- Successor to the 2-read/1-write register file.
- Adds configurable read and write port counts, a reset-driven initialisation sweep, per-port read enables with a valid flag, and write-collision resolution.
- Sits between ID (read addresses) and WB (write-back), feeding ID/EX operand registers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W (derived localparam).
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports (1..4).
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes.
- INIT_MODE, 1, sweep value: 0 writes zero to every entry; 1 writes the entry's own index (R[i]=i).

Ports:
- clk, in, 1, single clock, all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- init_done, out, 1, high once the init sweep has completed.
- rd_en, in, NUM_RD, per-port read enable.
- rd_addr, in, NUM_RD*ADDR_W, flattened read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W, flattened registered read data.
- rd_valid, out, NUM_RD, per-port read-data valid.
- wr_en, in, NUM_WR, per-port write enable.
- wr_addr, in, NUM_WR*ADDR_W, flattened write addresses.
- wr_data, in, NUM_WR*DATA_W, flattened write data.

Behaviour:
- Reset: one clock (clk); reset asynchronous, active-low (rst_n).
  - While rst_n=0: state=INIT, sweep counter=0, init_done=0, rd_data=0, rd_valid=0.
  - Array contents are not reset directly.
- FSM, 2 states:
  - INIT: each cycle writes the INIT_MODE value to entry[cnt] and increments cnt. The cycle that writes entry DEPTH-1 transitions to RUN.
  - RUN: terminal until the next reset.
  - init_done is registered; it goes high the first cycle in RUN, i.e. DEPTH cycles after rst_n deasserts.
- During INIT:
  - External writes are dropped.
  - rd_valid=0; rd_data holds 0.
- Read path, latency 1:
  - On each edge in RUN with rd_en[k]=1: rd_data[k] <= entry[rd_addr[k]] (pre-write array value), and rd_valid[k] <= 1.
  - With rd_en[k]=0: rd_data[k] holds its value and rd_valid[k] <= 0.
  - ZERO_REG=1 and address 0: rd_data[k] <= 0.
- Write path:
  - In RUN, wr_en[j]=1 writes wr_data[j] to entry[wr_addr[j]] at the clock edge.
  - ZERO_REG=1: writes to address 0 are discarded.
  - Collision (two enabled write ports, same address): the highest-index port wins; the others are discarded with no error.
- Read/write same address, same cycle, no bypass: the read returns the old value; the new value is visible from the next read.
- Reset mid-operation: async return to INIT; sweep restarts at 0; in-flight writes are lost.
- rd_addr/wr_addr values are always in range (DEPTH = 2**ADDR_W), so no bounds check.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a same-cycle write bypasses to the read. If an enabled write port in RUN targets rd_addr[k] (and the address is not 0 with ZERO_REG=1), rd_data[k] captures that wr_data; the collision winner applies.
  - Removes the WB-to-ID hazard without negedge reads.
- Undefined: read-old semantics as described above.

Decomposition:
- Package regfile_pkg:
  - State enum (ST_INIT, ST_RUN).
  - Default DATA_W/ADDR_W constants.
  - Function for the INIT_MODE value.
  - Function for the highest-index collision winner.
- Sub-module regfile_init_seq: the sweep counter plus FSM. Outputs the sweep write enable, address and data, and init_done.
- The top module muxes sweep writes against external writes.

Test Plan:
All scenarios use the defaults with NUM_RD=2 and NUM_WR=2.
- Reset release: deassert rst_n -> init_done=0 for 32 cycles, 1 on cycle 32. Then read addr 7 -> rd_data=7 one cycle later, rd_valid=1. With INIT_MODE=0 -> rd_data=0.
- Write then read: write port0 addr 4 data 0x10 -> next-cycle read of addr 4 returns 0x10. Write to addr 0 with 0xFFFF -> read addr 0 returns 0.
- Collision: port0 and port1 both write addr 9, data 0xAAAA and 0x5555 -> read addr 9 returns 0x5555.
- Same-cycle read/write at addr 3 with data 0x33:
  - Without the macro -> rd_data=3.
  - With REGFILE_BYPASS_EN -> 0x33.
  - Either way, the following read -> 0x33.
- Enable and reset:
  - rd_en=0 -> rd_data holds its prior value and rd_valid=0.
  - Assert rst_n low mid-RUN -> rd_data=0 and init_done=0 immediately (asynchronously). After release, addr 4 reads 4 again after the sweep.
  - A write attempted during INIT is dropped: write addr 5 = 0x99 during INIT -> addr 5 reads 5.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default widths and helpers for regfile_mp.
package regfile_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Value the init sweep stores into entry idx: 0, or the index itself.
  function automatic logic [31:0] init_value(input int unsigned mode, input int unsigned idx);
    return (mode == 0) ? 32'd0 : idx;
  endfunction

  // Index of the highest set bit in hits, or -1 when none is set.
  // Used to pick the winning write port when several target one address.
  function automatic int highest_hit(input logic [3:0] hits);
    int w;
    w = -1;
    for (int i = 0; i < 4; i++) begin
      if (hits[i]) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: post-reset sweep that initialises every register file
// entry once, then parks in RUN until the next reset.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              sweep_we_o,
  output logic [ADDR_W-1:0] sweep_addr_o,
  output logic [DATA_W-1:0] sweep_data_o,
  output logic              init_done_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q;

  // State, sweep counter and done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // Next state: one entry per cycle; the cycle writing the last entry enters RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sweep_we_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we_o = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  assign sweep_addr_o = cnt_q;
  assign sweep_data_o = DATA_W'(init_value(INIT_MODE, 32'(cnt_q)));
  assign init_done_o  = init_done_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, reset-driven
// init sweep and highest-port-wins write collisions.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_done,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic [DATA_W-1:0] sweep_data;
  logic              run;

  regfile_init_seq #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_MODE(INIT_MODE)
  ) u_init_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .sweep_we_o  (sweep_we),
    .sweep_addr_o(sweep_addr),
    .sweep_data_o(sweep_data),
    .init_done_o (run)
  );

  // Array update: sweep owns the array during INIT; in RUN ports write in
  // ascending order so the highest-index port wins a shared address.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= sweep_data;
    end else if (run) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0))
          mem_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Read-data next value: zeroed outside RUN, held when a port is disabled.
  always_comb begin
    logic [ADDR_W-1:0] ra;
`ifdef REGFILE_BYPASS_EN
    logic [3:0] hit;
    int         win;
    hit = '0;
    win = -1;
`endif
    ra         = '0;
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (!run) begin
        rd_data_d[k*DATA_W +: DATA_W] = '0;
      end else if (rd_en[k]) begin
        rd_valid_d[k] = 1'b1;
        if (ZERO_REG != 0 && ra == '0) begin
          rd_data_d[k*DATA_W +: DATA_W] = '0;
        end else begin
          rd_data_d[k*DATA_W +: DATA_W] = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
          hit = '0;
          for (int j = 0; j < NUM_WR; j++)
            hit[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra);
          win = highest_hit(hit);
          if (win >= 0) rd_data_d[k*DATA_W +: DATA_W] = wr_data[win*DATA_W +: DATA_W];
`endif
        end
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_done = run;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against a
// behavioural array model (NUM_RD=2, NUM_WR=2).
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data, rd_data_z;
  logic [1:0]  rd_valid, rd_valid_z;
  logic        init_done, init_done_z;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] exp_data [2];
  logic [1:0]  exp_valid;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .INIT_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .INIT_MODE(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_z),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_valid(rd_valid_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    for (int i = 0; i < 32; i++) model[i] = i;
    exp_data[0] = '0;
    exp_data[1] = '0;
    exp_valid   = '0;
  endtask

  // Drives one RUN cycle, derives the expected read results from the model,
  // then applies the writes to the model (later port overrides earlier).
  task automatic apply(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1);
    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    ra[0] = ra0; ra[1] = ra1;
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;
    rd_en   = re;
    rd_addr = {ra1, ra0};
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    for (int k = 0; k < 2; k++) begin
      exp_valid[k] = re[k];
      if (re[k]) begin
        if (ra[k] == 0) exp_data[k] = '0;
        else begin
          exp_data[k] = model[ra[k]];
`ifdef REGFILE_BYPASS_EN
          for (int j = 0; j < 2; j++)
            if (we[j] && wa[j] == ra[k]) exp_data[k] = wd[j];
`endif
        end
      end
    end
    for (int j = 0; j < 2; j++)
      if (we[j] && wa[j] != 0) model[wa[j]] = wd[j];
    cycle();
  endtask

  task automatic idle();
    rd_en = '0; wr_en = '0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    cycle(); cycle();
    checks++;
    if (init_done !== 1'b0 || rd_data !== 64'd0 || rd_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: init_done=%0b rd_data=%h rd_valid=%b want 0/0/0", init_done, rd_data, rd_valid);
    end
    model_init();
    rst_n = 1'b1;
    // A write held for the whole sweep must be dropped.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h99};
    rd_en = 2'b11; rd_addr = {5'd5, 5'd7};
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      cycle();
      n++;
      if (n == 31) begin
        checks++;
        if (rd_valid !== 2'b00 || rd_data !== 64'd0) begin
          errors++;
          $display("FAIL init_reads: rd_valid=%b rd_data=%h want 00/0", rd_valid, rd_data);
        end
      end
    end
    idle();
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL init_latency: done after %0d cycles want 32", n);
    end
    apply(2'b11, 5'd7, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++;
    if (rd_data[31:0] !== 32'd7 || rd_valid !== 2'b11) begin
      errors++;
      $display("FAIL init_read7: got %h valid %b want 7 valid 11", rd_data[31:0], rd_valid);
    end
    checks++;
    if (rd_data[63:32] !== 32'd5) begin
      errors++;
      $display("FAIL init_drop_write: addr5 got %h want 5", rd_data[63:32]);
    end
    checks++;
    if (rd_data_z[31:0] !== 32'd0 || init_done_z !== 1'b1) begin
      errors++;
      $display("FAIL init_mode0: got %h done %b want 0 done 1", rd_data_z[31:0], init_done_z);
    end
  endtask

  task automatic test_write_read();
    apply(2'b00, 5'd0, 5'd0, 2'b01, 5'd4, 32'h10, 5'd0, 32'd0);
    apply(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++;
    if (rd_data[31:0] !== 32'h10) begin
      errors++;
      $display("FAIL write_read4: got %h want 10", rd_data[31:0]);
    end
    apply(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFF);
    apply(2'b10, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++;
    if (rd_data[63:32] !== 32'd0 || rd_valid !== 2'b10) begin
      errors++;
      $display("FAIL zero_reg: got %h valid %b want 0 valid 10", rd_data[63:32], rd_valid);
    end
  endtask

  task automatic test_collision();
    apply(2'b00, 5'd0, 5'd0, 2'b11, 5'd9, 32'hAAAA, 5'd9, 32'h5555);
    apply(2'b11, 5'd9, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++;
    if (rd_data !== {32'h5555, 32'h5555}) begin
      errors++;
      $display("FAIL collision: got %h want 5555 on both ports", rd_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
    want = 32'h33;
`else
    want = 32'd3;
`endif
    apply(2'b01, 5'd3, 5'd0, 2'b01, 5'd3, 32'h33, 5'd0, 32'd0);
    checks++;
    if (rd_data[31:0] !== want) begin
      errors++;
      $display("FAIL same_cycle: got %h want %h", rd_data[31:0], want);
    end
    apply(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++;
    if (rd_data[31:0] !== 32'h33) begin
      errors++;
      $display("FAIL same_cycle_next: got %h want 33", rd_data[31:0]);
    end
  endtask

  task automatic test_enable_hold();
    apply(2'b11, 5'd12, 5'd4, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    apply(2'b00, 5'd1, 5'd2, 2'b11, 5'd12, 32'hDEAD, 5'd4, 32'hBEEF);
    apply(2'b00, 5'd12, 5'd4, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++;
    if (rd_data !== {32'h10, 32'd12} || rd_valid !== 2'b00) begin
      errors++;
      $display("FAIL enable_hold: got %h valid %b want %h valid 00", rd_data, rd_valid, {32'h10, 32'd12});
    end
  endtask

  task automatic test_random();
    logic [1:0]  re, we;
    logic [4:0]  ra0, ra1, wa0, wa1;
    logic [31:0] wd0, wd1;
    for (int c = 0; c < 300; c++) begin
      re  = 2'($urandom_range(0, 3));
      we  = 2'($urandom_range(0, 3));
      ra0 = 5'($urandom_range(0, (c % 2 == 0) ? 7 : 31));
      ra1 = 5'($urandom_range(0, 7));
      wa0 = 5'($urandom_range(0, 7));
      wa1 = 5'($urandom_range(0, (c % 3 == 0) ? 7 : 31));
      wd0 = $urandom;
      wd1 = $urandom;
      apply(re, ra0, ra1, we, wa0, wd0, wa1, wd1);
      checks++;
      if (rd_data !== {exp_data[1], exp_data[0]} || rd_valid !== exp_valid) begin
        errors++;
        $display("FAIL random[%0d]: rd_data=%h rd_valid=%b want %h %b", c, rd_data, rd_valid,
                 {exp_data[1], exp_data[0]}, exp_valid);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
    apply(2'b01, 5'd4, 5'd0, 2'b01, 5'd4, 32'h1234, 5'd0, 32'd0);
    apply(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data !== 64'd0 || init_done !== 1'b0 || rd_valid !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: rd_data=%h init_done=%b rd_valid=%b want 0/0/0", rd_data, init_done, rd_valid);
    end
    idle();
    cycle(); cycle();
    model_init();
    rst_n = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL reinit_latency: done after %0d cycles want 32", n);
    end
    apply(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++;
    if (rd_data[31:0] !== 32'd4 || rd_valid !== 2'b01) begin
      errors++;
      $display("FAIL reinit_read4: got %h valid %b want 4 valid 01", rd_data[31:0], rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_same_cycle();
    test_enable_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
